// File: rtl/fifo_param_peek.sv
// fifo_param_peek: parametrised packet FIFO with head peek, registered or FWFT read, zero-payload drop and sticky error flags
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   buf_in, wr_en    write data and write request
//   rd_en            read/pop request
//   clr_err          clears overflow/underflow
//   buf_out          read data (registered or fall-through)
//   nextPacket       head entry, 0 when empty
//   buf_empty, buf_full, almost_full, fifo_counter   occupancy status
//   overflow, underflow, drop_pulse                  error and drop indications
module fifo_param_peek #(
    parameter int DataWidth        = 67,
    parameter int PayloadLen       = 32,
    parameter int fifo_lg_size     = 4,
    parameter int ReadMode         = 0,
    parameter int AlmostFullMargin = 2,
    parameter int DropZeroPayload  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DataWidth-1:0]  buf_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DataWidth-1:0]  buf_out,
    output logic [DataWidth-1:0]  nextPacket,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic                  almost_full,
    output logic [fifo_lg_size:0] fifo_counter,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  drop_pulse
);
    localparam int FifoSize = 1 << fifo_lg_size;
    localparam logic [fifo_lg_size:0] CntFull = (fifo_lg_size + 1)'(FifoSize);
    localparam logic [fifo_lg_size:0] CntAf = (fifo_lg_size + 1)'(FifoSize - AlmostFullMargin);
    localparam logic [fifo_lg_size:0] CntOne = (fifo_lg_size + 1)'(1);
    localparam logic [fifo_lg_size-1:0] PtrOne = fifo_lg_size'(1);
    logic [DataWidth-1:0] mem [FifoSize];
    logic [fifo_lg_size-1:0] rd_ptr;
    logic [fifo_lg_size-1:0] wr_ptr;
    logic [DataWidth-1:0] out_reg;
    logic drop;
    logic rd_ok;
    logic wr_ok;
    always_comb begin
        buf_empty = fifo_counter == '0;
        buf_full = fifo_counter == CntFull;
        almost_full = fifo_counter >= CntAf;
        drop = DropZeroPayload != 0 && wr_en && buf_in[PayloadLen-1:0] == '0;
        rd_ok = rd_en && !buf_empty;
        // a full FIFO still takes a write when the same cycle frees a slot
        wr_ok = wr_en && !drop && (!buf_full || rd_ok);
        nextPacket = buf_empty ? '0 : mem[rd_ptr];
        buf_out = ReadMode != 0 ? nextPacket : out_reg;
    end
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) mem[wr_ptr] <= buf_in;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fifo_counter <= '0;
            out_reg <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PtrOne;
            if (rd_ok) rd_ptr <= rd_ptr + PtrOne;
            if (rd_ok) out_reg <= mem[rd_ptr];
            fifo_counter <= wr_ok && !rd_ok ? fifo_counter + CntOne :
                            rd_ok && !wr_ok ? fifo_counter - CntOne : fifo_counter;
            // set has priority over clear
            overflow <= (wr_en && !drop && buf_full && !rd_ok) ? 1'b1 : clr_err ? 1'b0 : overflow;
            underflow <= (rd_en && buf_empty) ? 1'b1 : clr_err ? 1'b0 : underflow;
            drop_pulse <= drop;
        end
    end
endmodule

// File: tb/tb_fifo_param_peek.sv
// tb_fifo_param_peek: directed bench for registered, no-drop and FWFT variants of fifo_param_peek
module tb_fifo_param_peek;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [66:0] buf_in = '0;
    logic wr_en = 1'b0;
    logic rd_en = 1'b0;
    logic clr_err = 1'b0;
    logic [66:0] bo0, np0, bo1, np1, bo2, np2;
    logic e0, f0, af0, ov0, un0, dp0;
    logic e1, f1, af1, ov1, un1, dp1;
    logic e2, f2, af2, ov2, un2, dp2;
    logic [2:0] fc0, fc1, fc2;
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    fifo_param_peek #(.fifo_lg_size(2), .ReadMode(0), .DropZeroPayload(1)) u0 (
        .clk(clk), .rst_n(rst_n), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
        .buf_out(bo0), .nextPacket(np0), .buf_empty(e0), .buf_full(f0), .almost_full(af0),
        .fifo_counter(fc0), .overflow(ov0), .underflow(un0), .drop_pulse(dp0));
    fifo_param_peek #(.fifo_lg_size(2), .ReadMode(0), .DropZeroPayload(0)) u1 (
        .clk(clk), .rst_n(rst_n), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
        .buf_out(bo1), .nextPacket(np1), .buf_empty(e1), .buf_full(f1), .almost_full(af1),
        .fifo_counter(fc1), .overflow(ov1), .underflow(un1), .drop_pulse(dp1));
    fifo_param_peek #(.fifo_lg_size(2), .ReadMode(1), .DropZeroPayload(1)) u2 (
        .clk(clk), .rst_n(rst_n), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
        .buf_out(bo2), .nextPacket(np2), .buf_empty(e2), .buf_full(f2), .almost_full(af2),
        .fifo_counter(fc2), .overflow(ov2), .underflow(un2), .drop_pulse(dp2));
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr_err = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask
    task automatic fill4(input logic [66:0] base);
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1;
            buf_in = base + 67'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask
    task automatic test_reset;
        do_reset();
        vectors++; if (fc0 !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", fc0); end
        vectors++; if ({e0, f0, af0} !== 3'b100) begin miscompares++; $display("FAIL reset_flags got %b want 100", {e0, f0, af0}); end
        vectors++; if ({ov0, un0, dp0} !== 3'b000) begin miscompares++; $display("FAIL reset_err got %b want 000", {ov0, un0, dp0}); end
        vectors++; if (bo0 !== 67'd0) begin miscompares++; $display("FAIL reset_buf_out got %h want 0", bo0); end
        vectors++; if (np0 !== 67'd0) begin miscompares++; $display("FAIL reset_peek got %h want 0", np0); end
        vectors++; if (bo2 !== 67'd0) begin miscompares++; $display("FAIL reset_fwft_out got %h want 0", bo2); end
    endtask
    task automatic test_fill_drain;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1;
            buf_in = 67'(i);
            tick();
            vectors++; if (fc0 !== 3'(i)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", i, fc0, i); end
            vectors++; if (af0 !== (i >= 2)) begin miscompares++; $display("FAIL fill_almost_full[%0d] got %b want %b", i, af0, i >= 2); end
            vectors++; if (f0 !== (i == 4)) begin miscompares++; $display("FAIL fill_full[%0d] got %b want %b", i, f0, i == 4); end
        end
        wr_en = 1'b0;
        vectors++; if (np0 !== 67'd1) begin miscompares++; $display("FAIL fill_peek got %h want 1", np0); end
        for (int i = 1; i <= 4; i++) begin
            rd_en = 1'b1;
            tick();
            vectors++; if (bo0 !== 67'(i)) begin miscompares++; $display("FAIL drain_out[%0d] got %h want %h", i, bo0, i); end
        end
        rd_en = 1'b0;
        vectors++; if ({e0, fc0} !== 4'b1000) begin miscompares++; $display("FAIL drain_empty got %b want 1000", {e0, fc0}); end
        vectors++; if (np0 !== 67'd0) begin miscompares++; $display("FAIL drain_peek got %h want 0", np0); end
        vectors++; if (un0 !== 1'b0) begin miscompares++; $display("FAIL drain_underflow got %b want 0", un0); end
    endtask
    task automatic test_wrap;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            buf_in = 67'h10 + 67'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (np0 !== 67'h10 + 67'(i)) begin miscompares++; $display("FAIL wrap_peek_a[%0d] got %h want %h", i, np0, 67'h10 + 67'(i)); end
            rd_en = 1'b1;
            tick();
            vectors++; if (bo0 !== 67'h10 + 67'(i)) begin miscompares++; $display("FAIL wrap_out_a[%0d] got %h want %h", i, bo0, 67'h10 + 67'(i)); end
        end
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            buf_in = 67'h20 + 67'(i);
            tick();
            vectors++; if (np0 !== 67'h20) begin miscompares++; $display("FAIL wrap_peek_fill[%0d] got %h want 20", i, np0); end
        end
        wr_en = 1'b0;
        vectors++; if (f0 !== 1'b1) begin miscompares++; $display("FAIL wrap_full got %b want 1", f0); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (np0 !== 67'h20 + 67'(i)) begin miscompares++; $display("FAIL wrap_peek_b[%0d] got %h want %h", i, np0, 67'h20 + 67'(i)); end
            rd_en = 1'b1;
            tick();
            vectors++; if (bo0 !== 67'h20 + 67'(i)) begin miscompares++; $display("FAIL wrap_out_b[%0d] got %h want %h", i, bo0, 67'h20 + 67'(i)); end
        end
        rd_en = 1'b0;
        vectors++; if (e0 !== 1'b1) begin miscompares++; $display("FAIL wrap_empty got %b want 1", e0); end
    endtask
    task automatic test_full_rw;
        logic [66:0] exp [4];
        exp[0] = 67'd2; exp[1] = 67'd3; exp[2] = 67'd4; exp[3] = 67'h55;
        do_reset();
        fill4(67'd0);
        rd_en = 1'b1; wr_en = 1'b1; buf_in = 67'h55;
        tick();
        vectors++; if (fc0 !== 3'd4) begin miscompares++; $display("FAIL full_rw_count got %0d want 4", fc0); end
        vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL full_rw_overflow got %b want 0", ov0); end
        vectors++; if (bo0 !== 67'd1) begin miscompares++; $display("FAIL full_rw_out got %h want 1", bo0); end
        rd_en = 1'b0; buf_in = 67'h66;
        tick();
        vectors++; if ({ov0, fc0} !== 4'b1100) begin miscompares++; $display("FAIL full_wr_overflow got %b want 1100", {ov0, fc0}); end
        clr_err = 1'b1;
        tick();
        vectors++; if (ov0 !== 1'b1) begin miscompares++; $display("FAIL set_beats_clear got %b want 1", ov0); end
        wr_en = 1'b0;
        tick();
        clr_err = 1'b0;
        vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL clr_overflow got %b want 0", ov0); end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            tick();
            vectors++; if (bo0 !== exp[i]) begin miscompares++; $display("FAIL full_drain[%0d] got %h want %h", i, bo0, exp[i]); end
        end
        rd_en = 1'b0;
        vectors++; if (e0 !== 1'b1) begin miscompares++; $display("FAIL full_drain_empty got %b want 1", e0); end
    endtask
    task automatic test_empty_rw;
        do_reset();
        rd_en = 1'b1; wr_en = 1'b1; buf_in = 67'h07;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        vectors++; if (un0 !== 1'b1) begin miscompares++; $display("FAIL empty_rw_underflow got %b want 1", un0); end
        vectors++; if (fc0 !== 3'd1) begin miscompares++; $display("FAIL empty_rw_count got %0d want 1", fc0); end
        vectors++; if (np0 !== 67'h07) begin miscompares++; $display("FAIL empty_rw_peek got %h want 07", np0); end
        vectors++; if (bo0 !== 67'd0) begin miscompares++; $display("FAIL empty_rw_out got %h want 0", bo0); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        vectors++; if (un0 !== 1'b0) begin miscompares++; $display("FAIL clr_underflow got %b want 0", un0); end
    endtask
    task automatic test_drop;
        do_reset();
        wr_en = 1'b1; buf_in = {35'h5, 32'h0};
        tick();
        wr_en = 1'b0;
        vectors++; if ({dp0, ov0, fc0} !== 5'b10000) begin miscompares++; $display("FAIL drop_state got %b want 10000", {dp0, ov0, fc0}); end
        vectors++; if (fc1 !== 3'd1) begin miscompares++; $display("FAIL nodrop_count got %0d want 1", fc1); end
        vectors++; if (np1 !== {35'h5, 32'h0}) begin miscompares++; $display("FAIL nodrop_peek got %h want %h", np1, {35'h5, 32'h0}); end
        vectors++; if (dp1 !== 1'b0) begin miscompares++; $display("FAIL nodrop_pulse got %b want 0", dp1); end
        tick();
        vectors++; if (dp0 !== 1'b0) begin miscompares++; $display("FAIL drop_pulse_len got %b want 0", dp0); end
        fill4(67'h100);
        wr_en = 1'b1; buf_in = {35'h1, 32'h0};
        tick();
        wr_en = 1'b0;
        vectors++; if ({dp0, ov0, fc0} !== 5'b10100) begin miscompares++; $display("FAIL drop_full got %b want 10100", {dp0, ov0, fc0}); end
    endtask
    task automatic test_fwft;
        do_reset();
        wr_en = 1'b1; buf_in = 67'h0A;
        tick();
        wr_en = 1'b0;
        vectors++; if (bo2 !== 67'h0A) begin miscompares++; $display("FAIL fwft_out got %h want 0A", bo2); end
        vectors++; if (bo0 !== 67'd0) begin miscompares++; $display("FAIL reg_no_read got %h want 0", bo0); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++; if ({e2, bo2} !== {1'b1, 67'd0}) begin miscompares++; $display("FAIL fwft_pop got %b/%h want 1/0", e2, bo2); end
        wr_en = 1'b1; buf_in = 67'h0B;
        tick();
        buf_in = 67'h0C;
        tick();
        wr_en = 1'b0;
        vectors++; if (bo2 !== 67'h0B) begin miscompares++; $display("FAIL fwft_head got %h want 0B", bo2); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++; if (bo2 !== 67'h0C) begin miscompares++; $display("FAIL fwft_next got %h want 0C", bo2); end
    endtask
    task automatic test_mid_reset;
        do_reset();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++; if (un0 !== 1'b1) begin miscompares++; $display("FAIL pre_reset_underflow got %b want 1", un0); end
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1;
            buf_in = 67'h30 + 67'(i);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++; if (bo0 !== 67'h31) begin miscompares++; $display("FAIL pre_reset_out got %h want 31", bo0); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++; if ({fc0, e0, un0, ov0, dp0} !== 7'b0001000) begin miscompares++; $display("FAIL mid_reset_state got %b want 0001000", {fc0, e0, un0, ov0, dp0}); end
        vectors++; if (bo0 !== 67'd0) begin miscompares++; $display("FAIL mid_reset_out got %h want 0", bo0); end
        vectors++; if ({np0, bo2} !== 134'd0) begin miscompares++; $display("FAIL mid_reset_peek got %h/%h want 0/0", np0, bo2); end
        wr_en = 1'b1; buf_in = 67'h44;
        tick();
        wr_en = 1'b0;
        vectors++; if ({fc0, np0} !== {3'd1, 67'h44}) begin miscompares++; $display("FAIL post_reset_write got %0d/%h want 1/44", fc0, np0); end
    endtask
    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_rw();
        test_empty_rw();
        test_drop();
        test_fwft();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
